// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the shared data RAM.
interface ram_arbiter_if;
  // requester side
  logic       req0, req1;
  logic       we0, we1;
  logic       lock0, lock1;
  logic [7:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1;
  logic       rvalid0, rvalid1;
  logic [7:0] rdata;
  // RAM side
  logic       ram_write;
  logic [7:0] ram_addr;
  logic [7:0] ram_data_in;
  logic [7:0] ram_data_out;

  modport slave (
    input  req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1,
    input  ram_data_out,
    output gnt0, gnt1, rvalid0, rvalid1, rdata,
    output ram_write, ram_addr, ram_data_in
  );

  modport master (
    output req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1,
    output ram_data_out,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata,
    input  ram_write, ram_addr, ram_data_in
  );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter for two requesters sharing one 256x8 synchronous RAM,
// with a bounded lock for atomic sequences and a registered read-valid strobe.
module ram_arbiter #(
  parameter int unsigned MAX_LOCK = 4
) (
  input  logic         clk,
  input  logic         reset,
  ram_arbiter_if.slave bus
);
  localparam logic [3:0] MAX_CNT = 4'(MAX_LOCK);

  typedef enum logic [1:0] {OWN_NONE, OWN_R0, OWN_R1} owner_e;

  owner_e     owner_q, owner_d;
  logic       last_q, last_d;          // requester granted most recently
  logic [3:0] lock_cnt_q, lock_cnt_d;  // grants taken in the current locked run
  logic       rvalid0_q, rvalid0_d;
  logic       rvalid1_q, rvalid1_d;

  logic       gnt0, gnt1, gnt_any;
  logic       sel_we, sel_lock;
  logic [7:0] sel_addr, sel_wdata;
  logic [3:0] run_nxt;

  // Grant decision: owner has exclusive access, otherwise round-robin on ties.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      case (owner_q)
        OWN_R0:  gnt0 = bus.req0;
        OWN_R1:  gnt1 = bus.req1;
        default: begin
          if (bus.req0 && bus.req1) begin
            gnt0 = last_q;
            gnt1 = !last_q;
          end else begin
            gnt0 = bus.req0;
            gnt1 = bus.req1;
          end
        end
      endcase
    end
  end

  assign gnt_any = gnt0 | gnt1;

  // Mux the granted requester's fields; idle bus is all zeros.
  always_comb begin
    sel_we    = 1'b0;
    sel_lock  = 1'b0;
    sel_addr  = 8'h00;
    sel_wdata = 8'h00;
    if (gnt0) begin
      sel_we = bus.we0; sel_lock = bus.lock0; sel_addr = bus.addr0; sel_wdata = bus.wdata0;
    end else if (gnt1) begin
      sel_we = bus.we1; sel_lock = bus.lock1; sel_addr = bus.addr1; sel_wdata = bus.wdata1;
    end
  end

  // The run count includes this grant; ownership is kept only while the run
  // stays below MAX_LOCK, so a lock yields at most MAX_LOCK back-to-back grants.
  assign run_nxt = lock_cnt_q + 4'd1;

  // Next-state: ownership, round-robin pointer and read-valid strobes.
  always_comb begin
    owner_d    = owner_q;
    last_d     = last_q;
    lock_cnt_d = lock_cnt_q;
    rvalid0_d  = 1'b0;
    rvalid1_d  = 1'b0;
    if (gnt_any) begin
      last_d    = gnt1;
      rvalid0_d = gnt0 & ~bus.we0;
      rvalid1_d = gnt1 & ~bus.we1;
      if (sel_lock && (run_nxt < MAX_CNT)) begin
        owner_d    = gnt1 ? OWN_R1 : OWN_R0;
        lock_cnt_d = run_nxt;
      end else begin
        owner_d    = OWN_NONE;
        lock_cnt_d = 4'd0;
      end
    end else if (owner_q != OWN_NONE) begin
      // owner dropped its request: lock abandoned
      owner_d    = OWN_NONE;
      lock_cnt_d = 4'd0;
    end
  end

  // State registers; reset releases any lock and discards pending read results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q    <= OWN_NONE;
      last_q     <= 1'b1;
      lock_cnt_q <= 4'd0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      owner_q    <= owner_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
    end
  end

  assign bus.gnt0        = gnt0;
  assign bus.gnt1        = gnt1;
  assign bus.ram_write   = gnt_any & sel_we;
  assign bus.ram_addr    = sel_addr;
  assign bus.ram_data_in = sel_wdata;
  assign bus.rvalid0     = rvalid0_q;
  assign bus.rvalid1     = rvalid1_q;
  assign bus.rdata       = bus.ram_data_out;
endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_ram_arbiter;
  localparam int MAXL = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_pass = 0;
  int   n_total = 0;

  ram_arbiter_if bus ();

  ram_arbiter #(.MAX_LOCK(MAXL)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input int i);
    return (i == 16) ? 8'hA5 : (8'(i) ^ 8'h5A);
  endfunction

  // Behavioural 256x8 RAM with registered read port.
  logic [7:0] mem [256];
  logic       mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      mem_ready <= 1'b1;
    end else begin
      if (bus.ram_write) mem[bus.ram_addr] <= bus.ram_data_in;
      bus.ram_data_out <= mem[bus.ram_addr];
    end
  end

  // expected RAM contents
  logic [7:0] ref_mem [256];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req0 = 0; bus.we0 = 0; bus.lock0 = 0; bus.addr0 = 8'h00; bus.wdata0 = 8'h00;
    bus.req1 = 0; bus.we1 = 0; bus.lock1 = 0; bus.addr1 = 8'h00; bus.wdata1 = 8'h00;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    repeat (2) tick();
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 8'h50; bus.wdata0 = 8'h11;
    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 8'h51; bus.wdata1 = 8'h22;
    #1;
    n_total++;
    if ({bus.gnt1, bus.gnt0} !== 2'b00) $display("FAIL reset_gnt got=%b want=00", {bus.gnt1, bus.gnt0});
    else n_pass++;
    n_total++;
    if (bus.ram_write !== 1'b0) $display("FAIL reset_ram_write got=%b want=0", bus.ram_write);
    else n_pass++;
    n_total++;
    if ({bus.rvalid1, bus.rvalid0} !== 2'b00) $display("FAIL reset_rvalid got=%b want=00", {bus.rvalid1, bus.rvalid0});
    else n_pass++;
    // first tie after reset goes to requester 0
    bus.we0 = 0; bus.we1 = 0;
    reset = 1'b0;
    #1;
    n_total++;
    if ({bus.gnt1, bus.gnt0} !== 2'b01) $display("FAIL reset_first_tie got=%b want=01", {bus.gnt1, bus.gnt0});
    else n_pass++;
    clear_inputs();
    tick();
  endtask

  task automatic test_single_read();
    do_reset();
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 8'h10;
    #1;
    n_total++;
    if ({bus.gnt1, bus.gnt0} !== 2'b01) $display("FAIL read_gnt got=%b want=01", {bus.gnt1, bus.gnt0});
    else n_pass++;
    n_total++;
    if (bus.ram_addr !== 8'h10 || bus.ram_write !== 1'b0)
      $display("FAIL read_bus got addr=%h w=%b want addr=10 w=0", bus.ram_addr, bus.ram_write);
    else n_pass++;
    tick();
    bus.req0 = 0;
    n_total++;
    if ({bus.rvalid1, bus.rvalid0} !== 2'b01) $display("FAIL read_rvalid got=%b want=01", {bus.rvalid1, bus.rvalid0});
    else n_pass++;
    n_total++;
    if (bus.rdata !== 8'hA5) $display("FAIL read_rdata got=%h want=a5", bus.rdata);
    else n_pass++;
    #1;
    n_total++;
    if (bus.ram_write !== 1'b0 || bus.ram_addr !== 8'h00 || bus.ram_data_in !== 8'h00)
      $display("FAIL idle_bus got w=%b a=%h d=%h want 0/00/00", bus.ram_write, bus.ram_addr, bus.ram_data_in);
    else n_pass++;
    tick();
  endtask

  task automatic test_write_then_read();
    do_reset();
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 8'h20; bus.wdata0 = 8'h3C;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 8'h20;
    #1;
    n_total++;
    if ({bus.gnt1, bus.gnt0} !== 2'b01) $display("FAIL wr_first_gnt got=%b want=01", {bus.gnt1, bus.gnt0});
    else n_pass++;
    n_total++;
    if (bus.ram_write !== 1'b1 || bus.ram_addr !== 8'h20 || bus.ram_data_in !== 8'h3C)
      $display("FAIL wr_bus got w=%b a=%h d=%h want 1/20/3c", bus.ram_write, bus.ram_addr, bus.ram_data_in);
    else n_pass++;
    tick();
    ref_mem[8'h20] = 8'h3C;
    bus.req0 = 0;
    #1;
    n_total++;
    if ({bus.gnt1, bus.gnt0} !== 2'b10) $display("FAIL rd_second_gnt got=%b want=10", {bus.gnt1, bus.gnt0});
    else n_pass++;
    n_total++;
    if ({bus.rvalid1, bus.rvalid0} !== 2'b00) $display("FAIL wr_no_rvalid got=%b want=00", {bus.rvalid1, bus.rvalid0});
    else n_pass++;
    tick();
    bus.req1 = 0;
    n_total++;
    if (bus.rvalid1 !== 1'b1 || bus.rdata !== 8'h3C)
      $display("FAIL wr_rd_data got rv1=%b d=%h want 1/3c", bus.rvalid1, bus.rdata);
    else n_pass++;
    tick();
  endtask

  task automatic test_alternate();
    logic [1:0] prev;
    do_reset();
    bus.req0 = 1; bus.addr0 = 8'h05;
    bus.req1 = 1; bus.addr1 = 8'h06;
    prev = 2'b00;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_total++;
      if ({bus.gnt1, bus.gnt0} !== ((i % 2 == 0) ? 2'b01 : 2'b10))
        $display("FAIL alt_gnt cyc=%0d got=%b want=%b", i, {bus.gnt1, bus.gnt0}, (i % 2 == 0) ? 2'b01 : 2'b10);
      else n_pass++;
      if (i > 0) begin
        n_total++;
        if ({bus.rvalid1, bus.rvalid0} !== prev)
          $display("FAIL alt_rvalid cyc=%0d got=%b want=%b", i, {bus.rvalid1, bus.rvalid0}, prev);
        else n_pass++;
      end
      prev = (i % 2 == 0) ? 2'b01 : 2'b10;
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_lock_max();
    logic [1:0] want [6];
    want = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
    do_reset();
    bus.req1 = 1; bus.lock1 = 1; bus.addr1 = 8'h30;
    for (int i = 0; i < 6; i++) begin
      if (i == 1) begin bus.req0 = 1; bus.addr0 = 8'h31; end
      #1;
      n_total++;
      if ({bus.gnt1, bus.gnt0} !== want[i])
        $display("FAIL lock_max cyc=%0d got=%b want=%b", i, {bus.gnt1, bus.gnt0}, want[i]);
      else n_pass++;
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_lock_abandon();
    do_reset();
    bus.req0 = 1; bus.lock0 = 1; bus.addr0 = 8'h40;
    #1;
    n_total++;
    if ({bus.gnt1, bus.gnt0} !== 2'b01) $display("FAIL abandon_lock_gnt got=%b want=01", {bus.gnt1, bus.gnt0});
    else n_pass++;
    tick();
    bus.req0 = 0; bus.lock0 = 0;
    bus.req1 = 1; bus.addr1 = 8'h41;
    #1;
    n_total++;
    if ({bus.gnt1, bus.gnt0} !== 2'b00) $display("FAIL abandon_stall got=%b want=00", {bus.gnt1, bus.gnt0});
    else n_pass++;
    tick();
    #1;
    n_total++;
    if ({bus.gnt1, bus.gnt0} !== 2'b10) $display("FAIL abandon_release got=%b want=10", {bus.gnt1, bus.gnt0});
    else n_pass++;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req1 = 1; bus.lock1 = 1; bus.we1 = 0; bus.addr1 = 8'h33;
    #1;
    n_total++;
    if ({bus.gnt1, bus.gnt0} !== 2'b10) $display("FAIL rstmid_gnt got=%b want=10", {bus.gnt1, bus.gnt0});
    else n_pass++;
    tick();
    n_total++;
    if (bus.rvalid1 !== 1'b1) $display("FAIL rstmid_rvalid_before got=%b want=1", bus.rvalid1);
    else n_pass++;
    // owner keeps going with a locked write; reset lands in this cycle
    bus.we1 = 1; bus.addr1 = 8'h77; bus.wdata1 = 8'hEE;
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 8'h77;
    #1;
    reset = 1'b1;
    #1;
    n_total++;
    if (bus.rvalid1 !== 1'b0) $display("FAIL rstmid_rvalid_async got=%b want=0", bus.rvalid1);
    else n_pass++;
    n_total++;
    if ({bus.gnt1, bus.gnt0} !== 2'b00 || bus.ram_write !== 1'b0)
      $display("FAIL rstmid_no_access got gnt=%b w=%b want 00/0", {bus.gnt1, bus.gnt0}, bus.ram_write);
    else n_pass++;
    tick();
    reset = 1'b0;
    bus.we1 = 0; bus.lock1 = 0;
    #1;
    n_total++;
    if ({bus.gnt1, bus.gnt0} !== 2'b01) $display("FAIL rstmid_tie_after got=%b want=01", {bus.gnt1, bus.gnt0});
    else n_pass++;
    tick();
    bus.req0 = 0;
    n_total++;
    if (bus.rvalid0 !== 1'b1 || bus.rdata !== ref_mem[8'h77])
      $display("FAIL rstmid_write_dropped got rv0=%b d=%h want 1/%h", bus.rvalid0, bus.rdata, ref_mem[8'h77]);
    else n_pass++;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_random();
    int         m_owner, m_last, m_run, g;
    logic       act [2];
    logic       rwe [2];
    logic       rlk [2];
    logic [7:0] raddr [2];
    logic [7:0] rwd [2];
    logic [1:0] exp_g;
    logic       e_rv0, e_rv1;
    logic [7:0] e_rdata;
    do_reset();
    m_owner = -1; m_last = 1; m_run = 0;
    for (int k = 0; k < 2; k++) begin
      act[k] = 0; rwe[k] = 0; rlk[k] = 0; raddr[k] = 8'h00; rwd[k] = 8'h00;
    end
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (!act[k] && $urandom_range(3) != 0) begin
          act[k]   = 1;
          rwe[k]   = 1'($urandom_range(1));
          rlk[k]   = ($urandom_range(2) == 0);
          raddr[k] = 8'h40 | 8'($urandom_range(7));
          rwd[k]   = 8'($urandom);
        end
      end
      bus.req0 = act[0]; bus.we0 = rwe[0]; bus.lock0 = rlk[0]; bus.addr0 = raddr[0]; bus.wdata0 = rwd[0];
      bus.req1 = act[1]; bus.we1 = rwe[1]; bus.lock1 = rlk[1]; bus.addr1 = raddr[1]; bus.wdata1 = rwd[1];
      #1;
      // who should win this cycle
      if (m_owner >= 0)          g = act[m_owner] ? m_owner : -1;
      else if (act[0] && act[1]) g = 1 - m_last;
      else if (act[0])           g = 0;
      else if (act[1])           g = 1;
      else                       g = -1;
      exp_g = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
      n_total++;
      if ({bus.gnt1, bus.gnt0} !== exp_g)
        $display("FAIL rand_gnt cyc=%0d got=%b want=%b", c, {bus.gnt1, bus.gnt0}, exp_g);
      else n_pass++;
      n_total++;
      if (g >= 0) begin
        if (bus.ram_write !== rwe[g] || bus.ram_addr !== raddr[g] || bus.ram_data_in !== rwd[g])
          $display("FAIL rand_bus cyc=%0d got w=%b a=%h d=%h want %b/%h/%h", c,
                   bus.ram_write, bus.ram_addr, bus.ram_data_in, rwe[g], raddr[g], rwd[g]);
        else n_pass++;
      end else begin
        if (bus.ram_write !== 1'b0) $display("FAIL rand_idle_write cyc=%0d got=%b want=0", c, bus.ram_write);
        else n_pass++;
      end
      e_rv0 = (g == 0) && !rwe[0];
      e_rv1 = (g == 1) && !rwe[1];
      e_rdata = (g >= 0) ? ref_mem[raddr[g]] : 8'h00;
      // advance model
      if (g >= 0) begin
        m_last = g;
        if (rwe[g]) ref_mem[raddr[g]] = rwd[g];
        if (rlk[g] && (m_run + 1 < MAXL)) begin m_owner = g; m_run = m_run + 1; end
        else begin m_owner = -1; m_run = 0; end
        act[g] = 0;
      end else if (m_owner >= 0) begin
        m_owner = -1; m_run = 0;
      end
      tick();
      n_total++;
      if ({bus.rvalid1, bus.rvalid0} !== {e_rv1, e_rv0})
        $display("FAIL rand_rvalid cyc=%0d got=%b want=%b", c, {bus.rvalid1, bus.rvalid0}, {e_rv1, e_rv0});
      else n_pass++;
      if (e_rv0 || e_rv1) begin
        n_total++;
        if (bus.rdata !== e_rdata) $display("FAIL rand_rdata cyc=%0d got=%h want=%h", c, bus.rdata, e_rdata);
        else n_pass++;
      end
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    bus.ram_data_out = 8'h00;
    clear_inputs();
    reset = 1'b1;
    test_reset();
    test_single_read();
    test_write_then_read();
    test_alternate();
    test_lock_max();
    test_lock_abandon();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
